// File: rtl/fp_add_issue.sv
// Issue stage wrapping a multi-cycle floating-point adder: accepts an operand pair,
// short-circuits zero operands, otherwise starts the adder and waits (with timeout) for its answer.
module fp_add_issue #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic             add_done,
  input  logic [31:0]      add_ans,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_bypass,
  output logic             out_err,
  output logic [15:0]      op_count
);

  localparam int          CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        a_reg, a_next;
  logic [31:0]        b_reg, b_next;
  logic [TAG_W-1:0]   tag_reg, tag_next;
  logic [31:0]        result_reg, result_next;
  logic               bypass_reg, bypass_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [15:0]        op_count_reg, op_count_next;

  logic               a_zero, b_zero;
  logic [31:0]        bypass_val;

  // Zero test ignores the sign bit: +0 and -0 both bypass.
  assign a_zero = (in_a[30:0] == 31'd0);
  assign b_zero = (in_b[30:0] == 31'd0);

  always_comb begin
    bypass_val = in_a;
    case ({a_zero, b_zero})
      2'b11:   bypass_val = {in_a[31] & in_b[31], 31'd0};
      2'b10:   bypass_val = in_b;
      default: bypass_val = in_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      a_reg        <= 32'd0;
      b_reg        <= 32'd0;
      tag_reg      <= '0;
      result_reg   <= 32'd0;
      bypass_reg   <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
      op_count_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      tag_reg      <= tag_next;
      result_reg   <= result_next;
      bypass_reg   <= bypass_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
      op_count_reg <= op_count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    tag_next      = tag_reg;
    result_next   = result_reg;
    bypass_next   = bypass_reg;
    err_next      = err_reg;
    cnt_next      = cnt_reg;
    op_count_next = op_count_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next   = in_a;
          b_next   = in_b;
          tag_next = in_tag;
          if (a_zero || b_zero) begin
            result_next = bypass_val;
            bypass_next = 1'b1;
            err_next    = 1'b0;
            state_next  = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A done arriving on the final timeout cycle still wins over the abort.
        if (add_done) begin
          result_next = add_ans;
          bypass_next = 1'b0;
          err_next    = 1'b0;
          state_next  = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          result_next = QNAN;
          bypass_next = 1'b0;
          err_next    = 1'b1;
          state_next  = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESP: begin
        if (out_ready) begin
          op_count_next = op_count_reg + 16'd1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign add_start  = (state_reg == ISSUE);
  assign out_valid  = (state_reg == RESP);
  assign add_a      = a_reg;
  assign add_b      = b_reg;
  assign out_result = result_reg;
  assign out_tag    = tag_reg;
  assign out_bypass = bypass_reg;
  assign out_err    = err_reg;
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_fp_add_issue.sv
// Randomized bench for fp_add_issue: a small adder model answers start pulses and a
// reference model derives expected results, latency and counts from the zero-bypass rules.
module tb_fp_add_issue;
  localparam int TIMEOUT = 64;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = 32'd0, in_b = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             add_start;
  logic [31:0]      add_a, add_b;
  logic             add_done = 1'b0;
  logic [31:0]      add_ans = 32'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_bypass, out_err;
  logic [15:0]      op_count;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [15:0] exp_count = 16'd0;

  fp_add_issue #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_done(add_done), .add_ans(add_ans),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_bypass(out_bypass), .out_err(out_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_zero(input logic [31:0] x);
    return (x[30:23] == 8'd0) && (x[22:0] == 23'd0);
  endfunction

  // Zero-operand sum: the other operand, or a zero whose sign is negative only if both were.
  function automatic logic [31:0] zero_sum(input logic [31:0] a, input logic [31:0] b);
    if (is_zero(a) && is_zero(b)) return (a[31] && b[31]) ? 32'h8000_0000 : 32'h0000_0000;
    if (is_zero(a)) return b;
    return a;
  endfunction

  // d: cycles after add_start that the adder answers (<1 or >TIMEOUT means never).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input int d, input logic [31:0] ans, input int hold, input bit stray);
    logic [31:0] exp_res;
    bit          exp_byp, exp_err, got;
    int          k, exp_lat;
    exp_byp = is_zero(a) || is_zero(b);
    exp_err = 1'b0;
    @(negedge clk);
    check_val("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = TAG_W'($urandom);
    if (exp_byp) begin
      exp_res = zero_sum(a, b);
      check_val("bypass_no_start", add_start, 1'b0);
    end else begin
      if (d >= 1 && d <= TIMEOUT) begin
        exp_res = ans; exp_lat = d + 1;
      end else begin
        exp_res = 32'h7FC0_0000; exp_err = 1'b1; exp_lat = TIMEOUT + 1;
      end
      check_val("start_pulse", add_start, 1'b1);
      check_val("add_a", add_a, a);
      check_val("add_b", add_b, b);
      check_val("busy_ready", in_ready, 1'b0);
      add_done = stray; add_ans = ~ans;
      k = 0; got = 1'b0;
      while (!got && k < TIMEOUT + 8) begin
        @(negedge clk);
        k++;
        add_done = 1'b0;
        check_val("start_once", add_start, 1'b0);
        check_val("add_a_stable", add_a, a);
        check_val("add_b_stable", add_b, b);
        if (out_valid) got = 1'b1;
        else if (k == d) begin
          add_done = 1'b1; add_ans = ans;
        end
      end
      check_val("latency", k, exp_lat);
    end
    check_val("out_valid", out_valid, 1'b1);
    for (int h = 0; h < hold; h++) begin
      add_done = stray; add_ans = 32'hDEAD_BEEF;
      @(negedge clk);
      check_val("hold_valid", out_valid, 1'b1);
      check_val("hold_result", out_result, exp_res);
      check_val("hold_ready", in_ready, 1'b0);
      check_val("hold_count", op_count, exp_count);
    end
    add_done = 1'b0;
    check_val("result", out_result, exp_res);
    check_val("tag", out_tag, tag);
    check_val("bypass", out_bypass, exp_byp);
    check_val("err", out_err, exp_err);
    check_val("resp_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check_val("released", out_valid, 1'b0);
    check_val("op_count", op_count, exp_count);
    check_val("idle_ready", in_ready, 1'b1);
    $display("op a=%h b=%h tag=%0d d=%0d hold=%0d -> res=%h byp=%0b err=%0b cnt=%0d",
             a, b, tag, d, hold, out_result, out_bypass, out_err, op_count);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, out_valid, 1'b0);
    check_val({tag, "_start"}, add_start, 1'b0);
    check_val({tag, "_result"}, out_result, 32'd0);
    check_val({tag, "_tag"}, out_tag, 32'd0);
    check_val({tag, "_bypass"}, out_bypass, 1'b0);
    check_val({tag, "_err"}, out_err, 1'b0);
    check_val({tag, "_count"}, op_count, 32'd0);
    check_val({tag, "_add_a"}, add_a, 32'd0);
    check_val({tag, "_add_b"}, add_b, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          rd;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_val("post_reset_ready", in_ready, 1'b1);

    run_op(32'h3F80_0000, 32'h4000_0000, 4'd1, 5, 32'h4040_0000, 0, 1'b0);
    run_op(32'h0000_0000, 32'hC0A0_0000, 4'd7, 0, 32'd0, 0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 4'd2, 0, 32'd0, 1, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0000, 4'd3, 0, 32'd0, 0, 1'b0);
    run_op(32'h4120_0000, 32'h8000_0000, 4'd4, 0, 32'd0, 0, 1'b1);
    run_op(32'h3F80_0000, 32'h3F80_0000, 4'd5, -1, 32'd0, 0, 1'b0);
    run_op(32'h4080_0000, 32'hBF80_0000, 4'd6, TIMEOUT, 32'h4040_0000, 0, 1'b0);
    run_op(32'h4000_0000, 32'h4000_0000, 4'd8, 3, 32'h4080_0000, 10, 1'b1);
    run_op(32'h0000_0001, 32'h8040_0000, 4'd9, 1, 32'h1234_5678, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'd0};
      if ($urandom_range(0, 3) == 0) rb = {rb[31], 31'd0};
      rd = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 12));
      run_op(ra, rb, TAG_W'($urandom), rd, $urandom, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an adder wait discards the operation.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h3F80_0000; in_tag = 4'hA;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midwait_rst");
    check_val("midwait_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    exp_count = 16'd0;
    for (int i = 0; i < 6; i++) begin
      add_done = 1'b1; add_ans = 32'h4000_0000;
      @(negedge clk);
      check_val("after_rst_valid", out_valid, 1'b0);
      check_val("after_rst_ready", in_ready, 1'b1);
    end
    add_done = 1'b0;

    // Counter wrap from the maximum value.
    @(negedge clk);
    dut.op_count_reg <= 16'hFFFF;
    exp_count = 16'hFFFF;
    run_op(32'h0000_0000, 32'h3F80_0000, 4'd3, 0, 32'd0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
